xip_read_cache: RTL and testbench
=================================

Name: xip_read_cache

Overview:
- Direct-mapped, word-granular read cache on the APB path between the CPU-side APB master and the flash/SPI controller.
- Flash-range reads (FLASH_BASE..FLASH_END) that hit are answered locally with no SPI traffic.
- Misses are forwarded downstream, and the returned word is filled into the cache.
- All non-flash accesses (e.g. SPI registers at 0x10001000) pass through uncached. Flash writes are rejected with an error.

Parameters:
FLASH_BASE, 32'h30000000, first cacheable byte address
FLASH_END, 32'h3fffffff, last cacheable byte address
IDX_W, 4, index bits; 2**IDX_W entries of one 32-bit word each

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
in_paddr  in  32  upstream APB address
in_psel  in  1  upstream select
in_penable  in  1  upstream enable
in_pwrite  in  1  upstream write
in_pwdata  in  32  upstream write data
in_pstrb  in  4  upstream byte strobes
in_pready  out  1  upstream ready
in_prdata  out  32  upstream read data
in_pslverr  out  1  upstream error
out_paddr  out  32  downstream address
out_psel  out  1  downstream select
out_penable  out  1  downstream enable
out_pwrite  out  1  downstream write
out_pwdata  out  32  downstream write data
out_pstrb  out  4  downstream strobes
out_pready  in  1  downstream ready
out_prdata  in  32  downstream read data
out_pslverr  in  1  downstream error
flush  in  1  one-cycle pulse; invalidate all entries
hit_cnt  out  32  saturating count of cacheable read hits
miss_cnt  out  32  saturating count of cacheable read misses

Behaviour:
- Reset values:
  - Entry valid bits: all 0.
  - State: IDLE.
  - in_pready, in_pslverr, out_psel, out_penable, out_pwrite: 0.
  - in_prdata, out_paddr, out_pwdata, out_pstrb: 0.
  - hit_cnt, miss_cnt: 0.
- Reset asserted mid-transaction: abort, drop out_psel/out_penable next edge, no fill.
- Address split:
  - index = paddr[IDX_W+1:2].
  - tag = paddr[31:IDX_W+2].
  - paddr[1:0] ignored; line data is the aligned word.
- Classification in IDLE on in_psel && !in_penable (SETUP phase); request fields are latched:
  - Cacheable read: flash range && !pwrite.
  - Flash write: flash range && pwrite.
  - Pass-through: anything else.
- States: IDLE, HIT_RSP, ERR_RSP, FWD_SETUP, FWD_ACCESS, RSP.
  - IDLE -> HIT_RSP: cacheable read with valid[index] && tag match. hit_cnt+1.
  - IDLE -> ERR_RSP: flash write.
  - IDLE -> FWD_SETUP: cacheable miss (miss_cnt+1) or pass-through.
  - HIT_RSP: in_pready=1, in_prdata=entry data, in_pslverr=0 for exactly one cycle -> IDLE. Hit latency: ready in the first ACCESS cycle.
  - ERR_RSP: in_pready=1, in_pslverr=1, in_prdata=0 for one cycle -> IDLE. Nothing is forwarded.
  - FWD_SETUP: out_psel=1, out_penable=0, latched addr/write/wdata/strb driven -> FWD_ACCESS.
  - FWD_ACCESS: out_psel=1, out_penable=1, held until out_pready=1. On that edge: capture out_prdata/out_pslverr, drop out_psel/out_penable, -> RSP.
  - RSP: in_pready=1 with the captured data/err for one cycle -> IDLE.
- Fill on the FWD_ACCESS->RSP edge: only if cacheable miss && out_pslverr=0 && no flush seen since the miss was accepted. Sets valid, tag, data.
- Downstream errors are propagated unchanged and never filled.
- in_pready is 0 in every cycle except the single response cycle.
- Upstream must hold signals until in_pready. Upstream signal changes mid-transaction are ignored (latched copy used).
- Flush:
  - Clears all valid bits on the next edge, in any state.
  - Flush during FWD_SETUP/FWD_ACCESS: set a discard flag, the pending fill is suppressed, but the data is still returned upstream.
  - Flush in the same cycle as a fill edge: flush wins, entry ends invalid.
  - A flush in IDLE coincident with a SETUP: the lookup uses the pre-flush valid bits, and the flush still applies.
- Counters saturate at 32'hffffffff. They are counted once per accepted cacheable read. Pass-through and error accesses are not counted.
- Back-to-back accesses: the next SETUP is accepted in the cycle after the response cycle.

Test Plan:
- Read 0x30000010 twice; downstream returns 0xDEADBEEF after 20 cycles -> first read: one downstream transaction, miss_cnt=1. Second read: in_pready in the first ACCESS cycle, data 0xDEADBEEF, no out_psel activity, hit_cnt=1.
- Conflict: read 0x30000010, then 0x30000050 (same index at IDX_W=4, different tag), then 0x30000010 -> three downstream transactions, miss_cnt=3, hit_cnt=0.
- Write to 0x30000000 -> in_pslverr=1, in_pready for one cycle, out_psel never asserted. Write to 0x10001014 with data 0x1 -> forwarded with pwrite=1 and pstrb=4'hf, counters unchanged.
- Miss on 0x30000020 with flush pulsed during FWD_ACCESS -> upstream still gets the data. A re-read misses (miss_cnt=2).
- Downstream returns pslverr=1 on a miss to 0x30000040 -> upstream sees pslverr=1. A re-read misses again.
- Preload miss_cnt to 32'hfffffffe via forced misses or a backdoor force, issue 3 misses -> miss_cnt saturates at 32'hffffffff. Then assert reset during FWD_ACCESS -> out_psel=0 next cycle, all counters 0, next read misses.

Source files
------------

// File: rtl/xip_read_cache.sv
// Direct-mapped, word-granular read cache between the CPU APB master and the flash/SPI controller.
// Flash-range read hits are answered locally, misses are forwarded and filled, flash writes error out.
module xip_read_cache #(
  parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
  parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
  parameter int unsigned IDX_W      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr,
  input  logic        flush,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = 30 - IDX_W;

  typedef enum logic [2:0] {
    IDLE, HIT_RSP, ERR_RSP, FWD_SETUP, FWD_ACCESS, RSP
  } state_e;

  state_e state_q, state_d;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [31:0]        data_q [ENTRIES];

  logic [31:0] req_addr_q, req_addr_d;
  logic        req_write_q, req_write_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_strb_q, req_strb_d;
  logic        req_cacheable_q, req_cacheable_d;
  logic        discard_q, discard_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] in_idx, req_idx;
  logic [TAG_W-1:0] in_tag, req_tag;
  logic             in_flash, accept, lookup_hit, fill;

  assign in_idx     = in_paddr[IDX_W+1:2];
  assign in_tag     = in_paddr[31:IDX_W+2];
  assign req_idx    = req_addr_q[IDX_W+1:2];
  assign req_tag    = req_addr_q[31:IDX_W+2];
  assign in_flash   = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
  assign accept     = (state_q == IDLE) && in_psel && !in_penable;
  // Lookup sees the registered valid bits, so a coincident flush does not hide this hit.
  assign lookup_hit = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
  assign fill       = (state_q == FWD_ACCESS) && out_pready && req_cacheable_q &&
                      !out_pslverr && !discard_q && !flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_flash && in_pwrite)       state_d = ERR_RSP;
          else if (in_flash && lookup_hit) state_d = HIT_RSP;
          else                             state_d = FWD_SETUP;
        end
      end
      HIT_RSP, ERR_RSP, RSP: state_d = IDLE;
      FWD_SETUP:             state_d = FWD_ACCESS;
      FWD_ACCESS:            if (out_pready) state_d = RSP;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d         = valid_q;
    req_addr_d      = req_addr_q;
    req_write_d     = req_write_q;
    req_wdata_d     = req_wdata_q;
    req_strb_d      = req_strb_q;
    req_cacheable_d = req_cacheable_q;
    discard_d       = discard_q;
    rsp_data_d      = rsp_data_q;
    rsp_err_d       = rsp_err_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;

    if (accept) begin
      req_addr_d      = in_paddr;
      req_write_d     = in_pwrite;
      req_wdata_d     = in_pwdata;
      req_strb_d      = in_pstrb;
      req_cacheable_d = in_flash && !in_pwrite;
      discard_d       = flush;
      rsp_err_d       = 1'b0;
      if (in_flash && !in_pwrite) begin
        if (lookup_hit) begin
          rsp_data_d = data_q[in_idx];
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
        end else if (miss_cnt_q != '1) begin
          miss_cnt_d = miss_cnt_q + 32'd1;
        end
      end
    end

    if (flush && ((state_q == FWD_SETUP) || (state_q == FWD_ACCESS))) discard_d = 1'b1;

    if ((state_q == FWD_ACCESS) && out_pready) begin
      rsp_data_d = out_prdata;
      rsp_err_d  = out_pslverr;
    end

    if (fill)  valid_d[req_idx] = 1'b1;
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q         <= '0;
      req_addr_q      <= '0;
      req_write_q     <= 1'b0;
      req_wdata_q     <= '0;
      req_strb_q      <= '0;
      req_cacheable_q <= 1'b0;
      discard_q       <= 1'b0;
      rsp_data_q      <= '0;
      rsp_err_q       <= 1'b0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      valid_q         <= valid_d;
      req_addr_q      <= req_addr_d;
      req_write_q     <= req_write_d;
      req_wdata_q     <= req_wdata_d;
      req_strb_q      <= req_strb_d;
      req_cacheable_q <= req_cacheable_d;
      discard_q       <= discard_d;
      rsp_data_q      <= rsp_data_d;
      rsp_err_q       <= rsp_err_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
    end
  end

  // Tag/data storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clock) begin
    if (fill && !reset) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= out_prdata;
    end
  end

  always_comb begin
    in_pready   = (state_q == HIT_RSP) || (state_q == ERR_RSP) || (state_q == RSP);
    in_prdata   = ((state_q == HIT_RSP) || (state_q == RSP)) ? rsp_data_q : '0;
    in_pslverr  = (state_q == ERR_RSP) || ((state_q == RSP) && rsp_err_q);
    out_psel    = (state_q == FWD_SETUP) || (state_q == FWD_ACCESS);
    out_penable = (state_q == FWD_ACCESS);
    out_pwrite  = out_psel && req_write_q;
    out_paddr   = req_addr_q;
    out_pwdata  = req_wdata_q;
    out_pstrb   = req_strb_q;
    hit_cnt     = hit_cnt_q;
    miss_cnt    = miss_cnt_q;
  end

endmodule

// File: tb/tb_xip_read_cache.sv
// Directed bench for xip_read_cache: an APB master and a downstream APB responder driven from one process.
module tb_xip_read_cache;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_paddr, in_pwdata, in_prdata;
  logic        in_psel, in_penable, in_pwrite, in_pready, in_pslverr;
  logic [3:0]  in_pstrb;
  logic [31:0] out_paddr, out_pwdata, out_prdata;
  logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
  logic [3:0]  out_pstrb;
  logic        flush;
  logic [31:0] hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] r_data, c_paddr, c_pwdata;
  logic        r_err, c_pwrite;
  logic [3:0]  c_pstrb;
  int          r_lat, r_txns;
  bit          r_psel_seen;

  always #5 clock = ~clock;

  xip_read_cache #(
    .FLASH_BASE(32'h3000_0000),
    .FLASH_END (32'h3fff_ffff),
    .IDX_W     (4)
  ) dut (
    .clock(clock), .reset(reset),
    .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable), .in_pwrite(in_pwrite),
    .in_pwdata(in_pwdata), .in_pstrb(in_pstrb), .in_pready(in_pready), .in_prdata(in_prdata),
    .in_pslverr(in_pslverr),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable), .out_pwrite(out_pwrite),
    .out_pwdata(out_pwdata), .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
    .out_pslverr(out_pslverr),
    .flush(flush), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  task automatic do_reset();
    in_paddr = '0; in_pwdata = '0; in_pstrb = '0;
    in_psel = 0; in_penable = 0; in_pwrite = 0;
    out_pready = 0; out_prdata = '0; out_pslverr = 0; flush = 0;
    reset = 1;
    repeat (2) @(negedge clock);
    reset = 0;
  endtask

  // One upstream transfer; the downstream side answers after ds_delay ACCESS cycles.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input int ds_delay, input logic [31:0] ds_data, input logic ds_err,
                      input int flush_at, input bit flush_setup);
    int acc;
    bit done;
    acc = 0; done = 0; r_txns = 0; r_lat = -1; r_psel_seen = 0;
    r_data = 'x; r_err = 'x;
    @(negedge clock);
    in_paddr = addr; in_pwrite = wr; in_pwdata = wdata; in_pstrb = 4'hf;
    in_psel = 1; in_penable = 0; flush = flush_setup;
    @(negedge clock);
    flush = 0; in_penable = 1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (out_psel) r_psel_seen = 1;
      if (out_psel && !out_penable) begin
        r_txns++;
        c_paddr = out_paddr; c_pwdata = out_pwdata; c_pwrite = out_pwrite; c_pstrb = out_pstrb;
      end
      out_pready = 0; flush = 0;
      if (in_pready) begin
        r_data = in_prdata; r_err = in_pslverr; r_lat = cyc; done = 1;
        in_psel = 0; in_penable = 0;
      end else if (out_psel && out_penable) begin
        acc++;
        if (acc == flush_at) flush = 1;
        if (acc >= ds_delay) begin
          out_pready = 1; out_prdata = ds_data; out_pslverr = ds_err;
        end
      end
      if (!done) @(negedge clock);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer_timeout addr %h: no in_pready within 200 cycles", addr);
      in_psel = 0; in_penable = 0; out_pready = 0; flush = 0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_pready, in_pslverr, out_psel, out_penable, out_pwrite} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000",
                         {in_pready, in_pslverr, out_psel, out_penable, out_pwrite});
    end
    checks++;
    if ({in_prdata, out_paddr, out_pwdata, out_pstrb} !== 100'b0) begin
      errors++; $display("FAIL reset_data got prdata %h paddr %h pwdata %h pstrb %h exp all 0",
                         in_prdata, out_paddr, out_pwdata, out_pstrb);
    end
    checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got hit %0d miss %0d exp 0 0", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_hit_miss();
    do_reset();
    xfer(32'h3000_0010, 0, '0, 20, 32'hDEAD_BEEF, 0, 0, 0);
    checks++;
    if (r_data !== 32'hDEAD_BEEF || r_err !== 1'b0 || r_txns != 1) begin
      errors++; $display("FAIL miss_first got data %h err %b txns %0d exp deadbeef 0 1", r_data, r_err, r_txns);
    end
    checks++;
    if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
      errors++; $display("FAIL miss_cnt got miss %0d hit %0d exp 1 0", miss_cnt, hit_cnt);
    end
    xfer(32'h3000_0010, 0, '0, 1, 32'h0BAD_0BAD, 0, 0, 0);
    checks++;
    if (r_data !== 32'hDEAD_BEEF || r_lat != 0 || r_psel_seen) begin
      errors++; $display("FAIL hit got data %h latency %0d psel_seen %0d exp deadbeef 0 0", r_data, r_lat, r_psel_seen);
    end
    checks++;
    if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
      errors++; $display("FAIL hit_cnt got hit %0d miss %0d exp 1 1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_conflict();
    int txns;
    do_reset();
    txns = 0;
    xfer(32'h3000_0010, 0, '0, 2, 32'h1111_1111, 0, 0, 0); txns += r_txns;
    xfer(32'h3000_0050, 0, '0, 2, 32'h2222_2222, 0, 0, 0); txns += r_txns;
    xfer(32'h3000_0010, 0, '0, 2, 32'h3333_3333, 0, 0, 0); txns += r_txns;
    checks++;
    if (txns != 3 || r_data !== 32'h3333_3333) begin
      errors++; $display("FAIL conflict got txns %0d data %h exp 3 33333333", txns, r_data);
    end
    checks++;
    if (miss_cnt !== 32'd3 || hit_cnt !== 32'd0) begin
      errors++; $display("FAIL conflict_cnt got miss %0d hit %0d exp 3 0", miss_cnt, hit_cnt);
    end
  endtask

  task automatic test_write();
    do_reset();
    xfer(32'h3000_0000, 1, 32'h1234_5678, 1, '0, 0, 0, 0);
    checks++;
    if (r_err !== 1'b1 || r_data !== 32'd0 || r_lat != 0 || r_psel_seen) begin
      errors++; $display("FAIL flash_write got err %b data %h lat %0d psel %0d exp 1 0 0 0", r_err, r_data, r_lat, r_psel_seen);
    end
    @(negedge clock);
    checks++;
    if (in_pready !== 1'b0) begin
      errors++; $display("FAIL err_one_cycle got in_pready %b exp 0", in_pready);
    end
    xfer(32'h1000_1014, 1, 32'h0000_0001, 3, '0, 0, 0, 0);
    checks++;
    if (r_txns != 1 || c_paddr !== 32'h1000_1014 || c_pwrite !== 1'b1 || c_pstrb !== 4'hf || c_pwdata !== 32'd1) begin
      errors++; $display("FAIL passthru_wr got txns %0d paddr %h pwrite %b pstrb %h pwdata %h exp 1 10001014 1 f 1",
                         r_txns, c_paddr, c_pwrite, c_pstrb, c_pwdata);
    end
    xfer(32'h1000_1000, 0, '0, 1, 32'hA5A5_0001, 0, 0, 0);
    xfer(32'h1000_1000, 0, '0, 1, 32'hA5A5_0002, 0, 0, 0);
    checks++;
    if (r_txns != 1 || r_data !== 32'hA5A5_0002 || hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++; $display("FAIL passthru_rd got txns %0d data %h hit %0d miss %0d exp 1 a5a50002 0 0",
                         r_txns, r_data, hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    xfer(32'h3000_0020, 0, '0, 5, 32'hCAFE_F00D, 0, 2, 0);
    checks++;
    if (r_data !== 32'hCAFE_F00D || r_err !== 1'b0) begin
      errors++; $display("FAIL flush_data got %h err %b exp cafef00d 0", r_data, r_err);
    end
    xfer(32'h3000_0020, 0, '0, 1, 32'hCAFE_F00E, 0, 0, 0);
    checks++;
    if (r_txns != 1 || miss_cnt !== 32'd2 || r_data !== 32'hCAFE_F00E) begin
      errors++; $display("FAIL flush_reread got txns %0d miss %0d data %h exp 1 2 cafef00e", r_txns, miss_cnt, r_data);
    end
    // Flush coincident with SETUP: this lookup still hits, the following one misses.
    xfer(32'h3000_0030, 0, '0, 1, 32'h1234_5678, 0, 0, 0);
    xfer(32'h3000_0030, 0, '0, 1, 32'h0BAD_0BAD, 0, 0, 1);
    checks++;
    if (r_txns != 0 || r_data !== 32'h1234_5678 || hit_cnt !== 32'd1) begin
      errors++; $display("FAIL flush_setup_hit got txns %0d data %h hit %0d exp 0 12345678 1", r_txns, r_data, hit_cnt);
    end
    xfer(32'h3000_0030, 0, '0, 1, 32'h8765_4321, 0, 0, 0);
    checks++;
    if (r_txns != 1 || miss_cnt !== 32'd4) begin
      errors++; $display("FAIL flush_setup_after got txns %0d miss %0d exp 1 4", r_txns, miss_cnt);
    end
  endtask

  task automatic test_ds_error();
    do_reset();
    xfer(32'h3000_0040, 0, '0, 2, 32'h5A5A_5A5A, 1, 0, 0);
    checks++;
    if (r_err !== 1'b1 || r_data !== 32'h5A5A_5A5A) begin
      errors++; $display("FAIL ds_err got err %b data %h exp 1 5a5a5a5a", r_err, r_data);
    end
    xfer(32'h3000_0040, 0, '0, 2, 32'h6B6B_6B6B, 0, 0, 0);
    checks++;
    if (r_txns != 1 || r_err !== 1'b0 || miss_cnt !== 32'd2 || hit_cnt !== 32'd0) begin
      errors++; $display("FAIL ds_err_reread got txns %0d err %b miss %0d hit %0d exp 1 0 2 0", r_txns, r_err, miss_cnt, hit_cnt);
    end
  endtask

  task automatic test_saturate_and_reset();
    int waited;
    @(negedge clock);
    force dut.miss_cnt_q = 32'hffff_fffe;
    @(negedge clock);
    release dut.miss_cnt_q;
    @(negedge clock);
    checks++;
    if (miss_cnt !== 32'hffff_fffe) begin
      errors++; $display("FAIL preload got %h exp fffffffe", miss_cnt);
    end
    xfer(32'h3000_0100, 0, '0, 1, 32'h0000_0100, 0, 0, 0);
    checks++;
    if (miss_cnt !== 32'hffff_ffff) begin
      errors++; $display("FAIL sat_step got %h exp ffffffff", miss_cnt);
    end
    xfer(32'h3000_0104, 0, '0, 1, 32'h0000_0104, 0, 0, 0);
    xfer(32'h3000_0108, 0, '0, 1, 32'h0000_0108, 0, 0, 0);
    checks++;
    if (miss_cnt !== 32'hffff_ffff) begin
      errors++; $display("FAIL sat_hold got %h exp ffffffff", miss_cnt);
    end

    // Abort a forwarded read with reset while it waits in ACCESS.
    @(negedge clock);
    in_paddr = 32'h3000_0070; in_pwrite = 0; in_psel = 1; in_penable = 0;
    @(negedge clock);
    in_penable = 1;
    waited = 0;
    while (!(out_psel && out_penable) && waited < 10) begin
      @(negedge clock); waited++;
    end
    checks++;
    if (!(out_psel && out_penable)) begin
      errors++; $display("FAIL reach_access got psel %b penable %b exp 1 1", out_psel, out_penable);
    end
    reset = 1;
    @(negedge clock);
    checks++;
    if (out_psel !== 1'b0 || out_penable !== 1'b0 || in_pready !== 1'b0) begin
      errors++; $display("FAIL abort got psel %b penable %b pready %b exp 0 0 0", out_psel, out_penable, in_pready);
    end
    checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++; $display("FAIL abort_cnt got hit %0d miss %0d exp 0 0", hit_cnt, miss_cnt);
    end
    in_psel = 0; in_penable = 0;
    reset = 0;
    xfer(32'h3000_0100, 0, '0, 1, 32'h7777_0100, 0, 0, 0);
    checks++;
    if (r_txns != 1 || r_data !== 32'h7777_0100 || miss_cnt !== 32'd1) begin
      errors++; $display("FAIL post_reset_miss got txns %0d data %h miss %0d exp 1 77770100 1", r_txns, r_data, miss_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_hit_miss();
    test_conflict();
    test_write();
    test_flush();
    test_ds_error();
    test_saturate_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
